dcache_block_mem_adapter: RTL and testbench
===========================================

# dcache_block_mem_adapter

Memory-side stage directly downstream of the data-cache controller. Accepts block-granularity read (refill) and write (writeback) requests on the controller's `mem*` interface and serialises them into `WORDS_PER_BLOCK` word beats on a word-wide req/ack memory port. It returns a full assembled block with a one-cycle `memReadReady` pulse, or signals write completion with a one-cycle `memWriteDone` pulse.

## Interface
- `BLOCK_ADDR_W`, 26: block address width.
- `WORD_W`, 32: memory word width.
- `WORDS_PER_BLOCK`, 4: beats per block; power of two, ≥2.
- `BLOCK_W`, `WORD_W*WORDS_PER_BLOCK`: block data width (derived).

Ports:
- `clock`  in  1  the design's single clock.
- `reset`  in  1  asynchronous, active-low reset.
- `memRen`  in  1  block read request from the cache controller.
- `memWen`  in  1  block write request from the cache controller.
- `memBlockAddr`  in  BLOCK_ADDR_W  block address.
- `memDin`  in  BLOCK_W  writeback block data.
- `memReadReady`  out  1  one-cycle pulse: `memDout` is valid.
- `memWriteDone`  out  1  one-cycle pulse: write accepted or complete (see Configuration).
- `memDout`  out  BLOCK_W  assembled read block.
- `wordReq`  out  1  word beat request.
- `wordWe`  out  1  beat is a write.
- `wordAddr`  out  BLOCK_ADDR_W+log2(WORDS_PER_BLOCK)  word address.
- `wordWdata`  out  WORD_W  write beat data.
- `wordAck`  in  1  beat completes on the rising edge where this is high.
- `wordRdata`  in  WORD_W  read data, valid when `wordAck` is high.

## Operation
- FSM states: IDLE, RD_BEAT, WR_BEAT, RD_DONE, WR_DONE.
- **IDLE:** requests are sampled only in this state.
  - On capture, latch `memBlockAddr` into `addr_q`, latch `memDin` into `blk_q`, and clear the beat counter `beat`.
  - `memWen` has priority if both requests are high. The read stays pending and is served on a later return to IDLE, because the controller holds `memRen`.
- **RD_BEAT / WR_BEAT:**
  - Outputs: `wordReq`=1, `wordAddr`={`addr_q`,`beat`}, `wordWe`=1 only in WR_BEAT, `wordWdata`=`blk_q[beat*WORD_W +: WORD_W]`.
  - All beat outputs hold stable until `wordAck`.
  - On an ack edge in RD_BEAT, store `wordRdata` into `memDout[beat*WORD_W +: WORD_W]`.
  - `beat` increments on each ack and wraps to 0 after the last beat. The last ack moves the FSM to RD_DONE or WR_DONE.
- **RD_DONE:** `memReadReady`=1 for exactly one cycle, then IDLE.
- **WR_DONE:** `memWriteDone`=1 for exactly one cycle, then IDLE.
- `memDout` holds its value until overwritten by the next read's beats. It must not be used outside the `memReadReady` cycle.
- `wordAck` outside RD_BEAT/WR_BEAT is ignored. `wordReq` is 0 in all other states.
- **Reset (async, any state):**
  - FSM returns to IDLE; `beat`, `memDout`, `addr_q` and `blk_q` clear to 0.
  - All outputs are 0.
  - An in-flight transfer is abandoned; a partial block write in external memory is permitted.

## Timing
- Request is sampled at edge E0; `wordReq` rises in the cycle after E0.
- With `wordAck` high on every beat cycle, a transfer takes `WORDS_PER_BLOCK` beat cycles, then one DONE cycle.
  - Example: `WORDS_PER_BLOCK`=4 gives `memReadReady` in the 5th cycle after E0.
- Each wait cycle (`wordAck` low) adds exactly one cycle.
- The requester deasserts its request in response to the done pulse. The request is not re-sampled before the cycle after DONE, so there is no double issue.
- Back-to-back: a new request present in the IDLE cycle following DONE is captured at that edge.

## Configuration
- Macro: `DCACHE_MEM_POSTED_WRITE_EN`.
- **Defined:**
  - A captured write pulses `memWriteDone` in the first cycle after E0, concurrent with beat 0.
  - WR_DONE is skipped: after the last write ack the FSM returns directly to IDLE.
  - A `memRen` arriving during the drain waits in IDLE-entry order. It is not sampled until the drain completes.
- **Undefined:** `memWriteDone` pulses in WR_DONE, after the last write ack.

## Test plan
- Read, `WORDS_PER_BLOCK`=4, `memBlockAddr`=0x10, `wordAck` every cycle, bench returns 0xA0..0xA3:
  - `wordAddr` 0x40..0x43 on consecutive cycles;
  - `memReadReady` one cycle, 5 cycles after E0;
  - `memDout`=0x000000A3_000000A2_000000A1_000000A0.
- Write `memDin`=0x44_33_22_11 words, `wordAck` stalled 2 cycles per beat:
  - `wordWdata` 0x11,0x22,0x33,0x44 held stable through stalls;
  - `memWriteDone` after 13 cycles (macro undefined);
  - with the macro: `memWriteDone` in cycle 1 and drain still finishes at beat 3.
- `memRen` and `memWen` high together:
  - write beats (`wordWe`=1) complete first, then read beats for the same address;
  - exactly one `memWriteDone` and one `memReadReady`.
- `reset` low mid-read at beat 2: all outputs 0 immediately (async); after release, a new read completes normally from beat 0.
- Back-to-back reads at 0x1 and 0x2:
  - second captured in the IDLE cycle after the first RD_DONE;
  - no gap beyond that cycle and no duplicate beats.
- Stray `wordAck` pulses in IDLE: no state change, no `memDout` update.

Source files
------------

// File: rtl/dcache_block_mem_adapter.sv
// Serialises data-cache block refills and writebacks into word beats on a req/ack memory port.
// Build option DCACHE_MEM_POSTED_WRITE_EN: acknowledge writes at capture and drain the beats afterwards.
module dcache_block_mem_adapter #(
    parameter int BLOCK_ADDR_W    = 26,
    parameter int WORD_W          = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int BLOCK_W         = WORD_W * WORDS_PER_BLOCK
) (
    input  logic                                            clock,
    input  logic                                            reset,
    input  logic                                            memRen,
    input  logic                                            memWen,
    input  logic [BLOCK_ADDR_W-1:0]                         memBlockAddr,
    input  logic [BLOCK_W-1:0]                              memDin,
    output logic                                            memReadReady,
    output logic                                            memWriteDone,
    output logic [BLOCK_W-1:0]                              memDout,
    output logic                                            wordReq,
    output logic                                            wordWe,
    output logic [BLOCK_ADDR_W+$clog2(WORDS_PER_BLOCK)-1:0] wordAddr,
    output logic [WORD_W-1:0]                               wordWdata,
    input  logic                                            wordAck,
    input  logic [WORD_W-1:0]                               wordRdata
);
    localparam int                BEAT_W    = $clog2(WORDS_PER_BLOCK);
    localparam int                WADDR_W   = BLOCK_ADDR_W + BEAT_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_BLOCK - 1);
    localparam logic [BEAT_W-1:0] ONE_BEAT  = BEAT_W'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_BEAT = 3'd1,
        WR_BEAT = 3'd2,
        RD_DONE = 3'd3,
        WR_DONE = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic [BLOCK_ADDR_W-1:0] addr_q, addr_d;
    logic [BLOCK_W-1:0]      blk_q, blk_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [BLOCK_W-1:0]      dout_q, dout_d;
    logic                    req_q, req_d;
    logic                    we_q, we_d;
    logic [WADDR_W-1:0]      waddr_q, waddr_d;
    logic [WORD_W-1:0]       wdata_q, wdata_d;
    logic                    rr_q, rr_d;
    logic                    wd_q, wd_d;
    logic                    wd_pulse_s;

    // Next-state, datapath and next-output computation; outputs are derived from next state so they register cleanly.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        blk_d      = blk_q;
        beat_d     = beat_q;
        dout_d     = dout_q;
        wd_pulse_s = 1'b0;
        case (state_q)
            IDLE: begin
                // A write wins a tie; the controller keeps memRen high so the read is served afterwards.
                if (memWen) begin
                    addr_d  = memBlockAddr;
                    blk_d   = memDin;
                    beat_d  = '0;
                    state_d = WR_BEAT;
`ifdef DCACHE_MEM_POSTED_WRITE_EN
                    wd_pulse_s = 1'b1;
`else
                    wd_pulse_s = 1'b0;
`endif
                end else if (memRen) begin
                    addr_d  = memBlockAddr;
                    blk_d   = memDin;
                    beat_d  = '0;
                    state_d = RD_BEAT;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_BEAT: begin
                if (wordAck) begin
                    dout_d[int'(beat_q)*WORD_W +: WORD_W] = wordRdata;
                    beat_d  = beat_q + ONE_BEAT;
                    state_d = (beat_q == LAST_BEAT) ? RD_DONE : RD_BEAT;
                end else begin
                    state_d = RD_BEAT;
                end
            end
            WR_BEAT: begin
                if (wordAck) begin
                    beat_d = beat_q + ONE_BEAT;
                    if (beat_q == LAST_BEAT) begin
`ifdef DCACHE_MEM_POSTED_WRITE_EN
                        state_d = IDLE;
`else
                        state_d = WR_DONE;
`endif
                    end else begin
                        state_d = WR_BEAT;
                    end
                end else begin
                    state_d = WR_BEAT;
                end
            end
            RD_DONE: state_d = IDLE;
            WR_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        req_d   = (state_d == RD_BEAT) || (state_d == WR_BEAT);
        we_d    = (state_d == WR_BEAT);
        waddr_d = {addr_d, beat_d};
        wdata_d = blk_d[int'(beat_d)*WORD_W +: WORD_W];
        rr_d    = (state_d == RD_DONE);
        wd_d    = (state_d == WR_DONE) || wd_pulse_s;
    end

    // State, datapath and output registers; asynchronous reset abandons any in-flight transfer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            blk_q   <= '0;
            beat_q  <= '0;
            dout_q  <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            rr_q    <= 1'b0;
            wd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            blk_q   <= blk_d;
            beat_q  <= beat_d;
            dout_q  <= dout_d;
            req_q   <= req_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            rr_q    <= rr_d;
            wd_q    <= wd_d;
        end
    end

    assign memReadReady = rr_q;
    assign memWriteDone = wd_q;
    assign memDout      = dout_q;
    assign wordReq      = req_q;
    assign wordWe       = we_q;
    assign wordAddr     = waddr_q;
    assign wordWdata    = wdata_q;

endmodule

// File: tb/tb_dcache_block_mem_adapter.sv
// Randomised self-checking bench: acts as cache controller and word memory, predicting beats and pulses per cycle.
module tb_dcache_block_mem_adapter;
`ifdef DCACHE_MEM_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          memRen, memWen;
    logic [25:0]   memBlockAddr;
    logic [127:0]  memDin;
    logic          memReadReady, memWriteDone;
    logic [127:0]  memDout;
    logic          wordReq, wordWe;
    logic [27:0]   wordAddr;
    logic [31:0]   wordWdata;
    logic          wordAck;
    logic [31:0]   wordRdata;

    always #5 clock = ~clock;

    dcache_block_mem_adapter dut (
        .clock(clock), .reset(reset),
        .memRen(memRen), .memWen(memWen), .memBlockAddr(memBlockAddr), .memDin(memDin),
        .memReadReady(memReadReady), .memWriteDone(memWriteDone), .memDout(memDout),
        .wordReq(wordReq), .wordWe(wordWe), .wordAddr(wordAddr), .wordWdata(wordWdata),
        .wordAck(wordAck), .wordRdata(wordRdata)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [31:0]   mem [logic [27:0]];
    logic          op_wr   [8];
    logic [25:0]   op_addr [8];
    logic [127:0]  op_din  [8];
    int            last_rr_k, last_wd_k;
    logic [127:0]  last_blk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Runs ops[0..n-1]; each request is raised when the previous one's done pulse is seen.
    task automatic run_ops(input int n, input bit both, input int smin, input int smax);
        int           start, cur, b, stall, rr_c, wd_c, last_k, nxt, n_rr, n_wd, n_rd_exp;
        bit           exp_req, done;
        logic [127:0] exp_blk;
        logic [27:0]  wa;
        exp_blk = '0; n_rr = 0; n_wd = 0; n_rd_exp = 0; done = 1'b0;
        for (int i = 0; i < n; i++) if (!op_wr[i]) n_rd_exp++;
        @(negedge clock);
        memBlockAddr = op_addr[0];
        memDin       = op_din[0];
        memWen       = op_wr[0];
        memRen       = !op_wr[0] || both;
        nxt    = both ? 2 : 1;
        cur    = 0;
        b      = 0;
        start  = 1;
        rr_c   = -1;
        wd_c   = (POSTED && op_wr[0]) ? 1 : -1;
        last_k = 0;
        stall  = $urandom_range(smax, smin);
        last_rr_k = 0;
        last_wd_k = 0;
        for (int k = 1; k <= 3000 && !done; k++) begin
            @(negedge clock);
            exp_req = (cur < n) && (k >= start);
            check_eq("wordReq", wordReq, exp_req);
            check_eq("memReadReady", memReadReady, k == rr_c);
            check_eq("memWriteDone", memWriteDone, k == wd_c);
            if (memReadReady) begin n_rr++; if (last_rr_k == 0) last_rr_k = k; end
            if (memWriteDone) begin n_wd++; if (last_wd_k == 0) last_wd_k = k; end
            if (k == rr_c) begin
                check_eq("memDout", memDout, exp_blk);
                last_blk = exp_blk;
                memRen   = 1'b0;
            end
            if (k == wd_c) memWen = 1'b0;
            if ((k == rr_c || k == wd_c) && nxt < n) begin
                memBlockAddr = op_addr[nxt];
                memDin       = op_din[nxt];
                if (op_wr[nxt]) memWen = 1'b1; else memRen = 1'b1;
                nxt++;
            end
            if (exp_req) begin
                wa = {op_addr[cur], 2'(b)};
                check_eq("wordAddr", wordAddr, wa);
                check_eq("wordWe", wordWe, op_wr[cur]);
                if (op_wr[cur]) check_eq("wordWdata", wordWdata, op_din[cur][b*32 +: 32]);
                if (stall > 0) begin
                    wordAck   = 1'b0;
                    wordRdata = $urandom;
                    stall--;
                end else begin
                    wordAck = 1'b1;
                    if (op_wr[cur]) begin
                        mem[wa]   = op_din[cur][b*32 +: 32];
                        wordRdata = $urandom;
                    end else begin
                        if (!mem.exists(wa)) mem[wa] = $urandom;
                        wordRdata = mem[wa];
                        exp_blk[b*32 +: 32] = mem[wa];
                    end
                    b++;
                    stall = $urandom_range(smax, smin);
                    if (b == 4) begin
                        if (!op_wr[cur]) rr_c = k + 1;
                        else if (!POSTED) wd_c = k + 1;
                        start  = k + ((op_wr[cur] && POSTED) ? 2 : 3);
                        last_k = k + 1;
                        cur++;
                        b = 0;
                        if (POSTED && cur < n && op_wr[cur]) wd_c = start;
                    end
                end
            end else begin
                wordAck   = 1'($urandom_range(1, 0));
                wordRdata = $urandom;
            end
            if (cur >= n && k > last_k) done = 1'b1;
        end
        wordAck = 1'b0;
        check_eq("timeout", done, 1'b1);
        check_eq("rr_count", n_rr, n_rd_exp);
        check_eq("wd_count", n_wd, n - n_rd_exp);
    endtask

    initial begin
        reset = 1'b0; memRen = 1'b0; memWen = 1'b0; memBlockAddr = '0; memDin = '0;
        wordAck = 1'b0; wordRdata = '0; last_blk = '0;
        #12;
        check_eq("rst_wordReq", wordReq, 1'b0);
        check_eq("rst_wordWe", wordWe, 1'b0);
        check_eq("rst_wordAddr", wordAddr, 28'h0);
        check_eq("rst_wordWdata", wordWdata, 32'h0);
        check_eq("rst_memReadReady", memReadReady, 1'b0);
        check_eq("rst_memWriteDone", memWriteDone, 1'b0);
        check_eq("rst_memDout", memDout, 128'h0);
        @(negedge clock);
        reset = 1'b1;

        // Directed read of block 0x10 returning 0xA0..0xA3.
        for (int i = 0; i < 4; i++) mem[28'h40 + 28'(i)] = 32'hA0 + 32'(i);
        op_wr[0] = 1'b0; op_addr[0] = 26'h10; op_din[0] = '0;
        run_ops(1, 1'b0, 0, 0);
        check_eq("rd_ready_cycle", last_rr_k, 5);
        check_eq("rd_block", memDout, 128'h000000A3_000000A2_000000A1_000000A0);

        // Stray acks in IDLE must change nothing.
        repeat (12) begin
            @(negedge clock);
            check_eq("idle_wordReq", wordReq, 1'b0);
            check_eq("idle_memReadReady", memReadReady, 1'b0);
            check_eq("idle_memDout", memDout, last_blk);
            wordAck   = 1'($urandom_range(1, 0));
            wordRdata = $urandom;
        end
        wordAck = 1'b0;

        // Write with two stall cycles per beat.
        op_wr[0] = 1'b1; op_addr[0] = 26'h5; op_din[0] = {32'h44, 32'h33, 32'h22, 32'h11};
        run_ops(1, 1'b0, 2, 2);
        check_eq("wr_done_cycle", last_wd_k, POSTED ? 1 : 13);

        // Simultaneous write and read to the same block: write first, read sees written data.
        op_wr[0] = 1'b1; op_wr[1] = 1'b0; op_addr[0] = 26'h9; op_addr[1] = 26'h9;
        op_din[0] = rand128(); op_din[1] = op_din[0];
        run_ops(2, 1'b1, 0, 1);
        check_eq("both_rd_data", memDout, op_din[0]);

        // Back-to-back reads.
        op_wr[0] = 1'b0; op_wr[1] = 1'b0; op_addr[0] = 26'h1; op_addr[1] = 26'h2;
        run_ops(2, 1'b0, 0, 0);

        // Asynchronous reset in the middle of a read at beat 2.
        @(negedge clock);
        memBlockAddr = 26'h7; memRen = 1'b1; wordAck = 1'b0;
        @(negedge clock);
        wordAck = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check_eq("pre_rst_wordAddr", wordAddr, {26'h7, 2'd2});
        wordAck = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_eq("arst_wordReq", wordReq, 1'b0);
        check_eq("arst_wordAddr", wordAddr, 28'h0);
        check_eq("arst_wordWe", wordWe, 1'b0);
        check_eq("arst_wordWdata", wordWdata, 32'h0);
        check_eq("arst_memReadReady", memReadReady, 1'b0);
        check_eq("arst_memWriteDone", memWriteDone, 1'b0);
        check_eq("arst_memDout", memDout, 128'h0);
        memRen = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        op_wr[0] = 1'b0; op_addr[0] = 26'h7;
        run_ops(1, 1'b0, 0, 1);

        // Randomised sequences over a small address range so reads hit earlier writes.
        for (int it = 0; it < 30; it++) begin
            int n;
            bit both;
            both = ($urandom_range(3, 0) == 0);
            if (both) begin
                n = 2;
                op_wr[0] = 1'b1; op_wr[1] = 1'b0;
                op_addr[0] = 26'($urandom_range(7, 0)); op_addr[1] = op_addr[0];
                op_din[0] = rand128(); op_din[1] = op_din[0];
            end else begin
                n = $urandom_range(3, 1);
                for (int i = 0; i < n; i++) begin
                    op_wr[i]   = 1'($urandom_range(1, 0));
                    op_addr[i] = 26'($urandom_range(7, 0));
                    op_din[i]  = rand128();
                end
            end
            run_ops(n, both, 0, $urandom_range(3, 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
